// File: rtl/wb_initiator_pkg.sv
// wb_initiator_pkg
// Shared types and constants for the Wishbone burst initiator.
//   state_t      : initiator sequencing states (IDLE, REQ, RSP)
//   RSP_OK       : beat terminated by ack
//   RSP_BUSERR   : beat terminated by err_i, burst aborted
//   RSP_TIMEOUT  : beat abandoned after the acknowledge timeout, burst aborted
package wb_initiator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  localparam logic [1:0] RSP_OK      = 2'b00;
  localparam logic [1:0] RSP_BUSERR  = 2'b01;
  localparam logic [1:0] RSP_TIMEOUT = 2'b10;

endpackage

// File: rtl/wb_initiator_timeout.sv
// wb_timeout_ctr
// Cycle counter that flags when a strobe has been outstanding for TIMEOUT
// cycles. The count restarts on clear and advances only while enabled.
// Ports:
//   clk     : clock
//   reset   : asynchronous active-high reset
//   clear   : restart the count at zero (wins over enable)
//   enable  : count this cycle
//   expired : high during the TIMEOUT-th enabled cycle after a clear
module wb_timeout_ctr #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  // 16 bits covers the full legal TIMEOUT range (2..65535).
  localparam int CW = 16;
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count;

  // Count enabled cycles since the last clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 16'd1;
    end
  end

  // The count starts at zero on the first enabled cycle, so reaching
  // TIMEOUT-1 marks the last cycle of a TIMEOUT-long window.
  assign expired = enable && !clear && (count == LIMIT);

endmodule

// File: rtl/wb_initiator.sv
// wb_initiator
// Wishbone classic (non-pipelined) burst initiator. Each accepted command
// becomes cmd_len+1 single-word transfers at incrementing word addresses,
// all inside one continuous cyc_o. Each beat yields one response on the
// rsp stream; bus errors and acknowledge timeouts abort the rest of the burst.
// Ports:
//   wb_clk_i, wb_rst_i           : clock, asynchronous active-high reset
//   cmd_valid/cmd_ready          : command handshake (ready only when idle)
//   cmd_we/adr/sel/dat/len       : direction, byte start address, byte select,
//                                  fill data, beats minus one
//   rsp_valid/rsp_ready          : response handshake
//   rsp_dat/rsp_err/rsp_last     : read data, status code, final response flag
//   wbm_*_o / wbm_*_i            : Wishbone master port
module wb_initiator
  import wb_initiator_pkg::*;
#(
  parameter int unsigned BURST_W = 4,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_we,
  input  logic [31:0]        cmd_adr,
  input  logic [3:0]         cmd_sel,
  input  logic [31:0]        cmd_dat,
  input  logic [BURST_W-1:0] cmd_len,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [31:0]        rsp_dat,
  output logic [1:0]         rsp_err,
  output logic               rsp_last,
  output logic               wbm_cyc_o,
  output logic               wbm_stb_o,
  output logic               wbm_we_o,
  output logic [3:0]         wbm_sel_o,
  output logic [31:0]        wbm_adr_o,
  output logic [31:0]        wbm_dat_o,
  input  logic               wbm_ack_i,
  input  logic               wbm_err_i,
  input  logic [31:0]        wbm_dat_i
);

  state_t             state;
  state_t             state_next;
  logic [29:0]        adr_word;
  logic [BURST_W-1:0] beat;
  logic [BURST_W-1:0] len_q;
  logic               timer_clear;
  logic               timer_en;
  logic               timer_expired;
  logic               unused_adr_lsbs;

  // Byte offset within a word is meaningless for word transfers.
  assign unused_adr_lsbs = ^cmd_adr[1:0];

  assign wbm_adr_o = {adr_word, 2'b00};

  wb_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (wb_clk_i),
    .reset   (wb_rst_i),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A beat ends on err, ack or timeout; a response
  // handshake either ends the command or launches the next beat.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (cmd_valid) state_next = REQ;
      REQ:  if (wbm_err_i || wbm_ack_i || timer_expired) state_next = RSP;
      RSP:  if (rsp_ready) state_next = rsp_last ? IDLE : REQ;
      default: state_next = IDLE;
    endcase
  end

  // Combinational outputs: command readiness and timer control. The timer
  // restarts on every entry into REQ so each beat gets a full window.
  always_comb begin
    cmd_ready   = (state == IDLE);
    timer_en    = (state == REQ);
    timer_clear = (state != REQ) && (state_next == REQ);
  end

  // Registered bus and response outputs. The response register is only
  // refilled from REQ, and REQ is only re-entered after the pending
  // response is consumed, so it can never be overwritten.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_dat_o <= '0;
      adr_word  <= '0;
      beat      <= '0;
      len_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_dat   <= '0;
      rsp_err   <= RSP_OK;
      rsp_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
            wbm_dat_o <= cmd_dat;
            adr_word  <= cmd_adr[31:2];
            len_q     <= cmd_len;
            beat      <= '0;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
          end
        end
        REQ: begin
          // err takes priority over ack; a silent responder hits the timeout.
          if (wbm_err_i) begin
            rsp_valid <= 1'b1;
            rsp_dat   <= '0;
            rsp_err   <= RSP_BUSERR;
            rsp_last  <= 1'b1;
            wbm_stb_o <= 1'b0;
          end else if (wbm_ack_i) begin
            rsp_valid <= 1'b1;
            rsp_dat   <= wbm_we_o ? 32'd0 : wbm_dat_i;
            rsp_err   <= RSP_OK;
            rsp_last  <= (beat == len_q);
            wbm_stb_o <= 1'b0;
          end else if (timer_expired) begin
            rsp_valid <= 1'b1;
            rsp_dat   <= '0;
            rsp_err   <= RSP_TIMEOUT;
            rsp_last  <= 1'b1;
            wbm_stb_o <= 1'b0;
          end
        end
        RSP: begin
          // cyc stays up between beats so a burst is one bus cycle; the
          // address wraps naturally at the top of the 32-bit space.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              wbm_cyc_o <= 1'b0;
            end else begin
              adr_word  <= adr_word + 30'd1;
              beat      <= beat + BURST_W'(1);
              wbm_stb_o <= 1'b1;
            end
          end
        end
        default: begin
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator
// Directed bench for wb_initiator: single read, wrapping write burst,
// acknowledge timeout, bus-error abort, response backpressure and
// asynchronous reset mid-transfer, against a small registered-ack responder.
module tb_wb_initiator;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [3:0]  cmd_sel;
  logic [31:0] cmd_dat;
  logic [3:0]  cmd_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic [1:0]  rsp_err;
  logic        rsp_last;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] wdat;
  logic        ack;
  logic        err;
  logic [31:0] s_dat;

  int errors = 0;
  int checks = 0;

  logic        silent;
  int          err_beat;
  logic [31:0] rd_data;
  int          resp_idx;
  int          stb_cycles = 0;
  int          stb_rises = 0;
  logic        stb_prev = 1'b0;

  wb_initiator #(
    .BURST_W (4),
    .TIMEOUT (16)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_adr   (cmd_adr),
    .cmd_sel   (cmd_sel),
    .cmd_dat   (cmd_dat),
    .cmd_len   (cmd_len),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_dat   (rsp_dat),
    .rsp_err   (rsp_err),
    .rsp_last  (rsp_last),
    .wbm_cyc_o (cyc),
    .wbm_stb_o (stb),
    .wbm_we_o  (we),
    .wbm_sel_o (sel),
    .wbm_adr_o (adr),
    .wbm_dat_o (wdat),
    .wbm_ack_i (ack),
    .wbm_err_i (err),
    .wbm_dat_i (s_dat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Responder: answers each fresh strobe one cycle later with ack, or with
  // err on the beat numbered err_beat; stays quiet when silent is set.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack      <= 1'b0;
      err      <= 1'b0;
      s_dat    <= '0;
      resp_idx <= 0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      if (!cyc) begin
        resp_idx <= 0;
      end else if (stb && !ack && !err && !silent) begin
        if (resp_idx == err_beat) begin
          err <= 1'b1;
        end else begin
          ack   <= 1'b1;
          s_dat <= rd_data;
        end
        resp_idx <= resp_idx + 1;
      end
    end
  end

  // Bus activity counters: strobe-high cycles and strobe rising edges.
  always @(posedge clk) begin
    if (stb) stb_cycles <= stb_cycles + 1;
    if (stb && !stb_prev) stb_rises <= stb_rises + 1;
    stb_prev <= stb;
  end

  // Hard stop in case the sequence stalls somewhere unexpected.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic c_we, input logic [31:0] c_adr,
                               input logic [3:0] c_sel, input logic [31:0] c_dat,
                               input logic [3:0] c_len);
    int n;
    n = 0;
    cmd_valid = 1'b1;
    cmd_we    = c_we;
    cmd_adr   = c_adr;
    cmd_sel   = c_sel;
    cmd_dat   = c_dat;
    cmd_len   = c_len;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    checkOutput("cmd_accept", 32'(cmd_ready), 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic waitStb(input string tag);
    int n;
    n = 0;
    while (!stb && n < 100) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(stb), 32'd1);
  endtask

  task automatic waitRsp(input string tag);
    int n;
    n = 0;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(rsp_valid), 32'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  logic [31:0] exp_adr [4];
  int s0;
  int r0;

  initial begin
    exp_adr[0] = 32'hFFFF_FFF8;
    exp_adr[1] = 32'hFFFF_FFFC;
    exp_adr[2] = 32'h0000_0000;
    exp_adr[3] = 32'h0000_0004;

    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_sel   = '0;
    cmd_dat   = '0;
    cmd_len   = '0;
    rsp_ready = 1'b0;
    silent    = 1'b0;
    err_beat  = -1;
    rd_data   = '0;
    #2;
    checkOutput("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("reset_cyc", 32'(cyc), 32'd0);
    checkOutput("reset_stb", 32'(stb), 32'd0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset_adr", adr, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    $display("[TB] single read");
    rd_data = 32'h0000_1234;
    s0 = stb_cycles;
    applyStimulus(1'b0, 32'h3000_0002, 4'hF, 32'd0, 4'd0);
    checkOutput("t1_stb_edge0", 32'(stb), 32'd1);
    checkOutput("t1_cyc_edge0", 32'(cyc), 32'd1);
    checkOutput("t1_adr", adr, 32'h3000_0000);
    checkOutput("t1_cmd_ready_busy", 32'(cmd_ready), 32'd0);
    tick();
    checkOutput("t1_stb_edge1", 32'(stb), 32'd1);
    checkOutput("t1_rsp_early", 32'(rsp_valid), 32'd0);
    tick();
    checkOutput("t1_rsp_valid_edge2", 32'(rsp_valid), 32'd1);
    checkOutput("t1_stb_drop", 32'(stb), 32'd0);
    checkOutput("t1_stb_cycles", 32'(stb_cycles - s0), 32'd2);
    checkOutput("t1_rsp_dat", rsp_dat, 32'h0000_1234);
    checkOutput("t1_rsp_err", 32'(rsp_err), 32'd0);
    checkOutput("t1_rsp_last", 32'(rsp_last), 32'd1);
    checkOutput("t1_cyc_held", 32'(cyc), 32'd1);
    handshake();
    checkOutput("t1_cyc_end", 32'(cyc), 32'd0);
    checkOutput("t1_rsp_cleared", 32'(rsp_valid), 32'd0);
    checkOutput("t1_cmd_ready_end", 32'(cmd_ready), 32'd1);

    $display("[TB] wrapping write burst");
    applyStimulus(1'b1, 32'hFFFF_FFF8, 4'hF, 32'hA5A5_0000, 4'd3);
    for (int b = 0; b < 4; b++) begin
      waitStb($sformatf("t2_stb_b%0d", b));
      checkOutput($sformatf("t2_adr_b%0d", b), adr, exp_adr[b]);
      checkOutput($sformatf("t2_we_b%0d", b), 32'(we), 32'd1);
      checkOutput($sformatf("t2_dat_b%0d", b), wdat, 32'hA5A5_0000);
      checkOutput($sformatf("t2_sel_b%0d", b), 32'(sel), 32'hF);
      waitRsp($sformatf("t2_rsp_b%0d", b));
      checkOutput($sformatf("t2_last_b%0d", b), 32'(rsp_last), 32'(b == 3));
      checkOutput($sformatf("t2_rdat_b%0d", b), rsp_dat, 32'd0);
      checkOutput($sformatf("t2_err_b%0d", b), 32'(rsp_err), 32'd0);
      checkOutput($sformatf("t2_cyc_b%0d", b), 32'(cyc), 32'd1);
      handshake();
    end
    checkOutput("t2_cyc_end", 32'(cyc), 32'd0);

    $display("[TB] acknowledge timeout");
    silent = 1'b1;
    s0 = stb_cycles;
    r0 = stb_rises;
    applyStimulus(1'b0, 32'h2000_0000, 4'hF, 32'd0, 4'd2);
    waitRsp("t3_rsp");
    checkOutput("t3_stb_cycles", 32'(stb_cycles - s0), 32'd16);
    checkOutput("t3_err", 32'(rsp_err), 32'd2);
    checkOutput("t3_last", 32'(rsp_last), 32'd1);
    checkOutput("t3_dat", rsp_dat, 32'd0);
    checkOutput("t3_stb_low", 32'(stb), 32'd0);
    handshake();
    checkOutput("t3_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("t3_cyc_end", 32'(cyc), 32'd0);
    tick();
    tick();
    tick();
    checkOutput("t3_strobes", 32'(stb_rises - r0), 32'd1);
    silent = 1'b0;

    $display("[TB] bus error abort");
    err_beat = 1;
    rd_data = 32'hCAFE_0001;
    r0 = stb_rises;
    applyStimulus(1'b0, 32'h0000_0100, 4'hF, 32'd0, 4'd3);
    waitRsp("t4_rsp_b0");
    checkOutput("t4_dat_b0", rsp_dat, 32'hCAFE_0001);
    checkOutput("t4_err_b0", 32'(rsp_err), 32'd0);
    checkOutput("t4_last_b0", 32'(rsp_last), 32'd0);
    checkOutput("t4_adr_b0", adr, 32'h0000_0100);
    handshake();
    waitRsp("t4_rsp_b1");
    checkOutput("t4_dat_b1", rsp_dat, 32'd0);
    checkOutput("t4_err_b1", 32'(rsp_err), 32'd1);
    checkOutput("t4_last_b1", 32'(rsp_last), 32'd1);
    checkOutput("t4_adr_b1", adr, 32'h0000_0104);
    handshake();
    checkOutput("t4_cyc_end", 32'(cyc), 32'd0);
    tick();
    tick();
    tick();
    checkOutput("t4_strobes", 32'(stb_rises - r0), 32'd2);
    err_beat = -1;

    $display("[TB] response backpressure");
    rd_data = 32'h0000_0055;
    applyStimulus(1'b0, 32'h0000_0500, 4'hF, 32'd0, 4'd1);
    waitRsp("t5_rsp_b0");
    s0 = stb_cycles;
    repeat (5) tick();
    checkOutput("t5_stb_hold", 32'(stb_cycles - s0), 32'd0);
    checkOutput("t5_adr_hold", adr, 32'h0000_0500);
    checkOutput("t5_rsp_hold", 32'(rsp_valid), 32'd1);
    checkOutput("t5_stb_low", 32'(stb), 32'd0);
    handshake();
    checkOutput("t5_stb_next", 32'(stb), 32'd1);
    checkOutput("t5_adr_next", adr, 32'h0000_0504);
    waitRsp("t5_rsp_b1");
    checkOutput("t5_last_b1", 32'(rsp_last), 32'd1);
    checkOutput("t5_dat_b1", rsp_dat, 32'h0000_0055);
    handshake();
    checkOutput("t5_cyc_end", 32'(cyc), 32'd0);

    $display("[TB] reset mid transfer");
    silent = 1'b1;
    applyStimulus(1'b0, 32'h0000_0600, 4'hF, 32'd0, 4'd0);
    tick();
    tick();
    checkOutput("t6_stb_before", 32'(stb), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("t6_cyc_async", 32'(cyc), 32'd0);
    checkOutput("t6_stb_async", 32'(stb), 32'd0);
    checkOutput("t6_rsp_async", 32'(rsp_valid), 32'd0);
    checkOutput("t6_cmd_ready_async", 32'(cmd_ready), 32'd1);
    tick();
    rst = 1'b0;
    tick();
    checkOutput("t6_cmd_ready_post", 32'(cmd_ready), 32'd1);
    silent = 1'b0;
    rd_data = 32'h0BAD_F00D;
    applyStimulus(1'b0, 32'h0000_0700, 4'h3, 32'd0, 4'd0);
    checkOutput("t6_adr", adr, 32'h0000_0700);
    checkOutput("t6_sel", 32'(sel), 32'h3);
    waitRsp("t6_rsp");
    checkOutput("t6_dat", rsp_dat, 32'h0BAD_F00D);
    checkOutput("t6_err", 32'(rsp_err), 32'd0);
    checkOutput("t6_last", 32'(rsp_last), 32'd1);
    handshake();
    checkOutput("t6_cyc_end", 32'(cyc), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_initiator.md
Name: wb_initiator

Overview:
Wishbone classic (B3, non-pipelined) bus initiator. It accepts one command per valid/ready handshake and executes it as 1..2^BURST_W single-word transfers at incrementing word addresses on a WB MI port. It returns one response per beat through a valid/ready stream, and applies a per-beat acknowledge timeout. It drives user-area responders (counter/peripheral slaves) from local sequencing logic rather than from the management SoC.

Parameters:
BURST_W, 4, width of cmd_len; a burst has cmd_len+1 beats (max 16).
TIMEOUT, 16, cycles stb_o may stay high without ack/err before the beat is abandoned; legal range 2..65535.

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  asynchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when valid&ready
cmd_we  in  1  1 = write burst, 0 = read burst
cmd_adr  in  32  start byte address; bits [1:0] ignored
cmd_sel  in  4  byte select applied to every beat
cmd_dat  in  32  write data, same value on every beat (fill)
cmd_len  in  BURST_W  beats minus one
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed when valid&ready
rsp_dat  out  32  read data; 0 for writes and errors
rsp_err  out  2  00 ok, 01 bus error, 10 timeout
rsp_last  out  1  final response of the command, including aborts
wbm_cyc_o  out  1  Wishbone cycle
wbm_stb_o  out  1  Wishbone strobe
wbm_we_o  out  1  write enable
wbm_sel_o  out  4  byte select
wbm_adr_o  out  32  word-aligned address; [1:0] always 00
wbm_dat_o  out  32  write data
wbm_ack_i  in  1  acknowledge
wbm_err_i  in  1  error termination
wbm_dat_i  in  32  read data

Behaviour:
- Reset (asynchronous, no clock edge needed): state IDLE; all outputs 0 except cmd_ready=1; beat counter and timer cleared. Reset mid-transfer drops cyc/stb immediately. The in-flight beat is lost and produces no response.
- All outputs are registered, except cmd_ready, which equals (state==IDLE).
- IDLE: on cmd_valid, latch we/sel/dat/len and adr[31:2]. Then cyc_o<=1, stb_o<=1, timer<=0, go REQ. stb is first high the cycle after acceptance.
- REQ: stb_o=1; timer increments each cycle.
  - ack_i sampled high: rsp_valid<=1, rsp_dat<=(we?0:dat_i), rsp_err<=00, rsp_last<=(beat==len), stb_o<=0, go RSP.
  - err_i high (priority over ack): rsp_err<=01, rsp_dat<=0, rsp_last<=1, stb_o<=0, abort flag set, go RSP.
  - timer==TIMEOUT-1 with neither ack nor err: rsp_err<=10, rsp_last<=1, stb_o<=0, abort, go RSP. stb is therefore high for exactly TIMEOUT cycles.
- RSP: stb_o=0 and cyc_o held at 1, so a burst is one continuous cycle. Wait for rsp_ready.
  - Handshake with rsp_last: rsp_valid<=0, cyc_o<=0, go IDLE.
  - Otherwise: adr<=adr+1 word (wraps modulo 2^32, so 0xFFFF_FFFC is followed by 0x0000_0000), beat+1, timer<=0, stb_o<=1, go REQ.
- Minimum per-beat spacing: stb deasserts for at least one cycle between beats. This guarantees registered-ack responders see a fresh strobe.
- Backpressure: no new strobe is issued while a response is pending. The single response register never overflows.
- ack or err seen outside REQ is ignored.
- Minimum latency with a responder that acks one cycle after stb: cmd accept edge 0; stb high cycles 1-2; rsp_valid from edge 2.

Decomposition:
- Package wb_initiator_pkg holds:
  - state enum {IDLE, REQ, RSP};
  - constants RSP_OK=2'b00, RSP_BUSERR=2'b01, RSP_TIMEOUT=2'b10.
- One sub-module, wb_timeout_ctr. It takes clear, enable, and the TIMEOUT parameter, and outputs an expired pulse. It is reused by future initiators.

Test Plan:
1. Single read, adr 0x3000_0002, len 0, responder acks 1 cycle after stb with 0x0000_1234 -> wbm_adr_o 0x3000_0000, stb high 2 cycles, one response dat 0x1234 err 00 last 1, cyc low the cycle after the handshake.
2. Write fill, adr 0xFFFF_FFF8, len 3, dat 0xA5A5_0000, sel 0xF -> 4 beats at 0xFFFF_FFF8, FFFC, 0000_0000, 0000_0004, we=1 each; cyc stays high throughout; 4 responses, last only on the 4th.
3. Timeout, TIMEOUT=16, responder silent -> stb high exactly 16 cycles; response err 10 last 1 dat 0; no further beats of a len-2 command; cmd_ready back to 1.
4. Read len 3, responder returns err_i on beat 1 -> beat0 err 00 last 0; beat1 err 01 last 1; exactly 2 strobes total.
5. Backpressure: read len 1, rsp_ready held low 5 cycles after the first response -> stb stays low and adr holds 5 cycles; second stb starts 1 cycle after the handshake.
6. Assert wb_rst_i mid-REQ between clock edges -> cyc/stb/rsp_valid go 0 immediately; after release cmd_ready=1 and the next command executes normally.
